// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter for async_fifo: pops FIFO words into a 2-entry register buffer
// and presents them on a valid/ready stream with registered outputs.
module async_fifo_rd_stream #(
    parameter int DSIZE = 32
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DSIZE-1:0] o_data,
    output logic [1:0]       o_level
);

    logic [DSIZE-1:0] entry_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             o_valid_r;
    logic [DSIZE-1:0] o_data_r;

    logic [DSIZE-1:0] entry_nxt_s [2];
    logic             wr_ptr_nxt_s;
    logic             rd_ptr_nxt_s;
    logic [1:0]       count_nxt_s;
    logic             pop_s;
    logic             deq_s;

    // Pop strobe: depends only on registered count plus rempty/flush, never on o_ready.
    // Gating with rrst_n keeps the FIFO untouched while this block is held in reset.
    always_comb begin
        pop_s = 1'b0;
        if (rrst_n && !rempty && !flush && (count_r < 2'd2)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign deq_s = o_valid_r & o_ready;

    // Next-state for buffer storage, pointers and occupancy.
    always_comb begin
        entry_nxt_s  = entry_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            // A same-cycle dequeue is still taken by the consumer; nothing to undo.
            wr_ptr_nxt_s = 1'b0;
            rd_ptr_nxt_s = 1'b0;
            count_nxt_s  = 2'd0;
        end else begin
            if (pop_s) begin
                entry_nxt_s[wr_ptr_r] = rdata;
                wr_ptr_nxt_s          = ~wr_ptr_r;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (deq_s) begin
                rd_ptr_nxt_s = ~rd_ptr_r;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({pop_s, deq_s})
                2'b10:   count_nxt_s = count_r + 2'd1;
                2'b01:   count_nxt_s = count_r - 2'd1;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // State registers; o_data/o_valid are precomputed so they leave straight from flops.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            entry_r[0] <= {DSIZE{1'b0}};
            entry_r[1] <= {DSIZE{1'b0}};
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            o_valid_r  <= 1'b0;
            o_data_r   <= {DSIZE{1'b0}};
        end else begin
            entry_r[0] <= entry_nxt_s[0];
            entry_r[1] <= entry_nxt_s[1];
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            o_valid_r  <= (count_nxt_s != 2'd0);
            o_data_r   <= entry_nxt_s[rd_ptr_nxt_s];
        end
    end

    assign rinc    = pop_s;
    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;
    assign o_level = count_r;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Randomized bench for async_fifo_rd_stream: the FIFO is modelled as a queue and the
// adapter buffer as a second queue of at most two words, updated from the stream rules.
module tb_async_fifo_rd_stream;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [31:0] rdata;
    logic        rinc;
    logic        flush;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [1:0]  o_level;

    logic [31:0] fifo_q[$];
    logic [31:0] mbuf[$];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_bad    = 0;
    int          pop_cnt  = 0;

    async_fifo_rd_stream #(.DSIZE(32)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_level (o_level)
    );

    always #5 rclk = ~rclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("o_valid", {31'd0, o_valid}, (mbuf.size() != 0) ? 32'd1 : 32'd0);
        check_eq("o_level", {30'd0, o_level}, 32'(mbuf.size()));
        if (mbuf.size() != 0) check_eq("o_data", o_data, mbuf[0]);
    endtask

    // One rclk cycle; called just after a falling edge, returns just after the next one.
    task automatic step(input logic rdy, input logic fl);
        logic exp_pop;
        logic exp_deq;
        rempty  = (fifo_q.size() == 0);
        rdata   = rempty ? $urandom : fifo_q[0];
        o_ready = rdy;
        flush   = fl;
        #1;
        exp_pop = !rempty && !fl && (mbuf.size() < 2);
        exp_deq = (mbuf.size() != 0) && rdy;
        check_eq("rinc", {31'd0, rinc}, {31'd0, exp_pop});
        @(posedge rclk);
        if (exp_deq) got_q.push_back(mbuf.pop_front());
        if (exp_pop) begin
            mbuf.push_back(fifo_q.pop_front());
            pop_cnt++;
        end
        if (fl) mbuf.delete();
        @(negedge rclk);
        check_outputs();
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq(tag, got_q[i], exp_q[i]);
    endtask

    initial begin
        int guard;
        int run;
        int max_run;
        int fed;
        rrst_n  = 1'b0;
        rempty  = 1'b1;
        rdata   = 32'd0;
        flush   = 1'b0;
        o_ready = 1'b0;
        #1;
        check_eq("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_o_level", {30'd0, o_level}, 32'd0);
        check_eq("rst_o_data", o_data, 32'd0);
        rempty = 1'b0;
        rdata  = 32'h1234;
        #1;
        check_eq("rst_rinc", {31'd0, rinc}, 32'd0);
        rempty = 1'b1;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;

        // T1 idle
        repeat (20) step(1'b1, 1'b0);
        check_eq("idle_o_data", o_data, 32'd0);

        // T2 single word
        fifo_q.push_back(32'hA);
        pop_cnt = 0; got_q.delete(); exp_q.delete(); exp_q.push_back(32'hA);
        repeat (5) step(1'b1, 1'b0);
        check_eq("single_pops", 32'(pop_cnt), 32'd1);
        check_stream("single");

        // T3 streaming 0..9
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            fifo_q.push_back(32'(i));
            exp_q.push_back(32'(i));
        end
        run = 0; max_run = 0;
        repeat (14) begin
            step(1'b1, 1'b0);
            run = o_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        check_eq("stream_valid_run", 32'(max_run), 32'd10);
        check_stream("stream");

        // T4 backpressure 0..15
        got_q.delete(); exp_q.delete(); pop_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            fifo_q.push_back(32'(i));
            exp_q.push_back(32'(i));
        end
        repeat (16) step(1'b0, 1'b0);
        check_eq("bp_pops", 32'(pop_cnt), 32'd2);
        check_eq("bp_level", {30'd0, o_level}, 32'd2);
        check_eq("bp_data", o_data, 32'd0);
        guard = 0;
        while (got_q.size() < 16 && guard < 200) begin
            step(1'b1, 1'b0);
            guard++;
        end
        check_eq("bp_timeout", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
        check_stream("bp");

        // T5 random ready and random FIFO arrival, 100 words
        got_q.delete(); exp_q.delete(); fed = 0; guard = 0;
        while ((got_q.size() < 100) && guard < 3000) begin
            if (fed < 100 && $urandom_range(1, 0) == 1) begin
                exp_q.push_back($urandom);
                fifo_q.push_back(exp_q[fed]);
                fed++;
            end
            step(1'($urandom_range(1, 0)), 1'b0);
            guard++;
        end
        check_eq("rand_timeout", (guard < 3000) ? 32'd1 : 32'd0, 32'd1);
        check_stream("rand");

        // T6a flush with two words held
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'(100 + i));
        repeat (3) step(1'b0, 1'b0);
        check_eq("fl_level_pre", {30'd0, o_level}, 32'd2);
        step(1'b0, 1'b1);
        check_eq("fl_level", {30'd0, o_level}, 32'd0);
        check_eq("fl_valid", {31'd0, o_valid}, 32'd0);
        exp_q.push_back(32'd102);
        repeat (4) step(1'b1, 1'b0);
        check_stream("flush_next");

        // T6b reset mid-stream
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'(200 + i));
        repeat (3) step(1'b0, 1'b0);
        check_eq("rs_level_pre", {30'd0, o_level}, 32'd2);
        #2;
        rrst_n = 1'b0;
        #1;
        check_eq("rs_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rs_o_level", {30'd0, o_level}, 32'd0);
        check_eq("rs_o_data", o_data, 32'd0);
        check_eq("rs_rinc", {31'd0, rinc}, 32'd0);
        mbuf.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
        exp_q.push_back(32'd202);
        repeat (4) step(1'b1, 1'b0);
        check_stream("reset_next");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
